// File: rtl/wm_pkg.sv
// Shared encodings for the washing-machine front panel: phase codes, mode values,
// coin-return FSM states and the phase-flag payload.
package wm_pkg;

  localparam int unsigned PH_W    = 3;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned TOTAL_W = 16;

  localparam logic [PH_W-1:0] PH_IDLE    = 3'd0;
  localparam logic [PH_W-1:0] PH_READY   = 3'd1;
  localparam logic [PH_W-1:0] PH_SOAK    = 3'd2;
  localparam logic [PH_W-1:0] PH_WASH    = 3'd3;
  localparam logic [PH_W-1:0] PH_RINSE   = 3'd4;
  localparam logic [PH_W-1:0] PH_SPIN    = 3'd5;
  localparam logic [PH_W-1:0] PH_INVALID = 3'd7;

  localparam logic [MODE_W-1:0] MODE1 = 2'd0;
  localparam logic [MODE_W-1:0] MODE2 = 2'd1;
  localparam logic [MODE_W-1:0] MODE3 = 2'd2;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_PULSE = 2'd1,
    R_GAP   = 2'd2
  } rtn_state_e;

  typedef struct packed {
    logic idle;
    logic ready;
    logic soak;
    logic wash;
    logic rinse;
    logic spin;
  } phase_flags_t;

  // Exactly one flag set maps to its code; anything else is invalid.
  function automatic logic [PH_W-1:0] phase_code(input phase_flags_t f);
    logic [5:0] v;
    v = f;
    case (v)
      6'b100000: phase_code = PH_IDLE;
      6'b010000: phase_code = PH_READY;
      6'b001000: phase_code = PH_SOAK;
      6'b000100: phase_code = PH_WASH;
      6'b000010: phase_code = PH_RINSE;
      6'b000001: phase_code = PH_SPIN;
      default:   phase_code = PH_INVALID;
    endcase
  endfunction

  function automatic logic [MODE_W-1:0] mode_next(input logic [MODE_W-1:0] m);
    case (m)
      MODE1:   mode_next = MODE2;
      MODE2:   mode_next = MODE3;
      default: mode_next = MODE1;
    endcase
  endfunction

endpackage

// File: rtl/wm_debounce.sv
// Two-flop synchroniser followed by a stable-sample debouncer for one raw switch.
module wm_debounce #(
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned DB_W      = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o
);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  // Any sample matching the current level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/wm_front_panel.sv
// Panel front end: debounced switches, coin credit, mode stepping, phase LEDs and
// coin-return solenoid sequencing. Define WM_COIN_COUNT_EN to build the coin_total counter.
module wm_front_panel
  import wm_pkg::*;
#(
  parameter int unsigned DB_CYCLES  = 4,
  parameter int unsigned DB_W       = 3,
  parameter int unsigned RTN_CYCLES = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               raw_lid,
  input  logic               raw_coin,
  input  logic               raw_cancel,
  input  logic               raw_mode_btn,
  input  logic               idle_op,
  input  logic               ready_op,
  input  logic               soak_op,
  input  logic               wash_op,
  input  logic               rinse_op,
  input  logic               spin_op,
  input  logic               coin_rtn,
  output logic               lid,
  output logic               coin,
  output logic               cancel,
  output logic [MODE_W-1:0]  mode,
  output logic               lid_lock,
  output logic               rtn_solenoid,
  output logic [PH_W-1:0]    phase_led,
  output logic               busy,
  output logic [TOTAL_W-1:0] coin_total
);

  localparam int unsigned TMR_MAX = (RTN_CYCLES > GAP_CYCLES) ? RTN_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  logic lid_db, coin_db, cancel_db, mode_db;

  wm_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_lid (
    .clk(clk), .rst_n(rst_n), .raw_i(raw_lid), .level_o(lid_db));
  wm_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_coin (
    .clk(clk), .rst_n(rst_n), .raw_i(raw_coin), .level_o(coin_db));
  wm_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_cancel (
    .clk(clk), .rst_n(rst_n), .raw_i(raw_cancel), .level_o(cancel_db));
  wm_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .raw_i(raw_mode_btn), .level_o(mode_db));

  logic              coin_q, coin_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              busy_q, busy_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              coin_prev_q, mode_prev_q, coin_rtn_q;
  logic [1:0]        pend_q, pend_d;
  logic [2:0]        pend_sum;
  rtn_state_e        state_q;
  logic [TMR_W-1:0]  tmr_q;
  logic              sol_q;

  logic coin_rise, mode_rise, accept, reject, rtn_edge, pulse_start;

  assign coin_rise = coin_db & ~coin_prev_q;
  assign mode_rise = mode_db & ~mode_prev_q;
  assign accept    = coin_rise & idle_op & ~coin_q;
  assign reject    = coin_rise & ~accept;
  assign rtn_edge  = coin_rtn & ~coin_rtn_q;

  // A pending return launches from idle, or straight out of the gap so the
  // off-time between back-to-back pulses is exactly GAP_CYCLES.
  assign pulse_start = (pend_q != 2'd0) &&
                       ((state_q == R_IDLE) ||
                        ((state_q == R_GAP) && (tmr_q == TMR_W'(GAP_CYCLES - 1))));

  always_comb begin
    coin_d = coin_q;
    if (ready_op || cancel_db) begin
      coin_d = 1'b0;
    end else if (accept) begin
      coin_d = 1'b1;
    end

    mode_d = mode_q;
    if (mode_rise && idle_op) begin
      mode_d = mode_next(mode_q);
    end

    busy_d  = soak_op | wash_op | rinse_op | spin_op;
    phase_d = phase_code(phase_flags_t'({idle_op, ready_op, soak_op, wash_op, rinse_op, spin_op}));

    pend_sum = 3'(pend_q) - 3'(pulse_start) + 3'(reject) + 3'(rtn_edge);
    pend_d   = (pend_sum > 3'd3) ? 2'd3 : pend_sum[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coin_q      <= 1'b0;
      mode_q      <= MODE1;
      busy_q      <= 1'b0;
      phase_q     <= PH_INVALID;
      coin_prev_q <= 1'b0;
      mode_prev_q <= 1'b0;
      coin_rtn_q  <= 1'b0;
      pend_q      <= 2'd0;
    end else begin
      coin_q      <= coin_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      phase_q     <= phase_d;
      coin_prev_q <= coin_db;
      mode_prev_q <= mode_db;
      coin_rtn_q  <= coin_rtn;
      pend_q      <= pend_d;
    end
  end

  // Coin-return sequencer: pulse for RTN_CYCLES, then hold off for GAP_CYCLES.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R_IDLE;
      tmr_q   <= '0;
      sol_q   <= 1'b0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (pulse_start) begin
            state_q <= R_PULSE;
            sol_q   <= 1'b1;
            tmr_q   <= '0;
          end
        end
        R_PULSE: begin
          if (tmr_q == TMR_W'(RTN_CYCLES - 1)) begin
            state_q <= R_GAP;
            sol_q   <= 1'b0;
            tmr_q   <= '0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        R_GAP: begin
          if (tmr_q == TMR_W'(GAP_CYCLES - 1)) begin
            tmr_q <= '0;
            if (pulse_start) begin
              state_q <= R_PULSE;
              sol_q   <= 1'b1;
            end else begin
              state_q <= R_IDLE;
            end
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        default: begin
          state_q <= R_IDLE;
          sol_q   <= 1'b0;
          tmr_q   <= '0;
        end
      endcase
    end
  end

`ifdef WM_COIN_COUNT_EN
  logic [TOTAL_W-1:0] total_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
    end else if (accept && (total_q != {TOTAL_W{1'b1}})) begin
      total_q <= total_q + 1'b1;
    end
  end

  assign coin_total = total_q;
`else
  assign coin_total = '0;
`endif

  assign lid          = lid_db;
  assign cancel       = cancel_db;
  assign coin         = coin_q;
  assign mode         = mode_q;
  assign busy         = busy_q;
  assign lid_lock     = busy_q;
  assign phase_led    = phase_q;
  assign rtn_solenoid = sol_q;

endmodule

// File: tb/tb_wm_front_panel.sv
// Directed bench for wm_front_panel: debounce timing, coin credit/reject, mode stepping,
// phase decode and coin-return pulse sequencing, with expected values written by hand.
module tb_wm_front_panel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        raw_lid, raw_coin, raw_cancel, raw_mode_btn;
  logic        idle_op, ready_op, soak_op, wash_op, rinse_op, spin_op;
  logic        coin_rtn;
  logic        lid, coin, cancel, lid_lock, rtn_solenoid, busy;
  logic [1:0]  mode;
  logic [2:0]  phase_led;
  logic [15:0] coin_total;

  int errors = 0;
  int checks = 0;

  wm_front_panel dut (
    .clk(clk), .rst_n(rst_n),
    .raw_lid(raw_lid), .raw_coin(raw_coin), .raw_cancel(raw_cancel), .raw_mode_btn(raw_mode_btn),
    .idle_op(idle_op), .ready_op(ready_op), .soak_op(soak_op), .wash_op(wash_op),
    .rinse_op(rinse_op), .spin_op(spin_op), .coin_rtn(coin_rtn),
    .lid(lid), .coin(coin), .cancel(cancel), .mode(mode), .lid_lock(lid_lock),
    .rtn_solenoid(rtn_solenoid), .phase_led(phase_led), .busy(busy), .coin_total(coin_total)
  );

  always #5 clk = ~clk;

  task automatic ncyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Flag order: idle, ready, soak, wash, rinse, spin.
  task automatic set_phase(input logic [5:0] f);
    {idle_op, ready_op, soak_op, wash_op, rinse_op, spin_op} = f;
  endtask

  // 0 = coin, 1 = mode button: clean press long enough to debounce both edges.
  task automatic press(input int which);
    if (which == 0) raw_coin = 1'b1; else raw_mode_btn = 1'b1;
    ncyc(8);
    if (which == 0) raw_coin = 1'b0; else raw_mode_btn = 1'b0;
    ncyc(10);
  endtask

  task automatic wait_sol(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rtn_solenoid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (rtn_solenoid && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (!rtn_solenoid && n < 30) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_any_high(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (rtn_solenoid) n++;
    end
  endtask

  task automatic test_reset;
    ncyc(3);
    checks += 9;
    if (lid !== 1'b0)        begin errors++; $display("FAIL reset_lid: got %0b expected 0", lid); end
    if (coin !== 1'b0)       begin errors++; $display("FAIL reset_coin: got %0b expected 0", coin); end
    if (cancel !== 1'b0)     begin errors++; $display("FAIL reset_cancel: got %0b expected 0", cancel); end
    if (mode !== 2'd0)       begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode); end
    if (lid_lock !== 1'b0)   begin errors++; $display("FAIL reset_lid_lock: got %0b expected 0", lid_lock); end
    if (rtn_solenoid !== 1'b0) begin errors++; $display("FAIL reset_solenoid: got %0b expected 0", rtn_solenoid); end
    if (phase_led !== 3'd7)  begin errors++; $display("FAIL reset_phase_led: got %0d expected 7", phase_led); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    if (coin_total !== 16'd0) begin errors++; $display("FAIL reset_coin_total: got %0d expected 0", coin_total); end
    rst_n = 1'b1;
    ncyc(2);
  endtask

  task automatic test_lid;
    bit seen = 1'b0;
    for (int g = 0; g < 3; g++) begin
      raw_lid = 1'b1;
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (lid) seen = 1'b1; end
      raw_lid = 1'b0;
      for (int i = 0; i < 3; i++) begin @(negedge clk); if (lid) seen = 1'b1; end
    end
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (lid) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL lid_glitch: got lid=1 expected lid=0"); end
    raw_lid = 1'b1;
    ncyc(5);
    checks++;
    if (lid !== 1'b0) begin errors++; $display("FAIL lid_edge_minus1: got %0b expected 0", lid); end
    ncyc(1);
    checks++;
    if (lid !== 1'b1) begin errors++; $display("FAIL lid_edge_6: got %0b expected 1", lid); end
    raw_lid = 1'b0;
    ncyc(8);
  endtask

  task automatic test_coin_accept;
    int hi;
    set_phase(6'b100000);
    ncyc(1);
    count_any_high(0, hi);
    press(0);
    checks++;
    if (coin !== 1'b1) begin errors++; $display("FAIL coin_accept: got %0b expected 1", coin); end
    ncyc(5);
    checks++;
    if (coin !== 1'b1) begin errors++; $display("FAIL coin_held: got %0b expected 1", coin); end
    set_phase(6'b010000);
    ncyc(1);
    checks++;
    if (coin !== 1'b0) begin errors++; $display("FAIL coin_ready_clear: got %0b expected 0", coin); end
    count_any_high(10, hi);
    checks++;
    if (hi !== 0) begin errors++; $display("FAIL coin_accept_no_return: got %0d high cycles expected 0", hi); end
  endtask

  task automatic test_coin_reject;
    bit ok;
    int n;
    set_phase(6'b001000);
    ncyc(2);
    raw_coin = 1'b1;
    wait_sol(ok);
    checks += 5;
    if (!ok) begin errors++; $display("FAIL reject_pulse_timeout: got no pulse expected pulse"); end
    if (coin !== 1'b0) begin errors++; $display("FAIL reject_coin: got %0b expected 0", coin); end
    if (lid_lock !== 1'b1) begin errors++; $display("FAIL reject_lid_lock: got %0b expected 1", lid_lock); end
    if (phase_led !== 3'd2) begin errors++; $display("FAIL reject_phase_led: got %0d expected 2", phase_led); end
    if (busy !== 1'b1) begin errors++; $display("FAIL reject_busy: got %0b expected 1", busy); end
    raw_coin = 1'b0;
    count_high(n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL reject_pulse_len: got %0d expected 8", n); end
    ncyc(12);
  endtask

  task automatic test_mode;
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd0; exp_seq[3] = 2'd1;
    set_phase(6'b100000);
    ncyc(1);
    for (int i = 0; i < 4; i++) begin
      press(1);
      checks++;
      if (mode !== exp_seq[i]) begin errors++; $display("FAIL mode_step%0d: got %0d expected %0d", i, mode, exp_seq[i]); end
    end
    set_phase(6'b000100);
    press(1);
    checks++;
    if (mode !== 2'd1) begin errors++; $display("FAIL mode_ignored_wash: got %0d expected 1", mode); end
  endtask

  task automatic test_phase;
    logic [5:0] flags [8];
    logic [2:0] exp_led [8];
    logic       exp_busy [8];
    flags[0] = 6'b100000; exp_led[0] = 3'd0; exp_busy[0] = 1'b0;
    flags[1] = 6'b010000; exp_led[1] = 3'd1; exp_busy[1] = 1'b0;
    flags[2] = 6'b001000; exp_led[2] = 3'd2; exp_busy[2] = 1'b1;
    flags[3] = 6'b000100; exp_led[3] = 3'd3; exp_busy[3] = 1'b1;
    flags[4] = 6'b000010; exp_led[4] = 3'd4; exp_busy[4] = 1'b1;
    flags[5] = 6'b000001; exp_led[5] = 3'd5; exp_busy[5] = 1'b1;
    flags[6] = 6'b000000; exp_led[6] = 3'd7; exp_busy[6] = 1'b0;
    flags[7] = 6'b001100; exp_led[7] = 3'd7; exp_busy[7] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_phase(flags[i]);
      ncyc(1);
      checks += 3;
      if (phase_led !== exp_led[i]) begin errors++; $display("FAIL phase_led%0d: got %0d expected %0d", i, phase_led, exp_led[i]); end
      if (busy !== exp_busy[i]) begin errors++; $display("FAIL busy%0d: got %0b expected %0b", i, busy, exp_busy[i]); end
      if (lid_lock !== exp_busy[i]) begin errors++; $display("FAIL lid_lock%0d: got %0b expected %0b", i, lid_lock, exp_busy[i]); end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n1, g, n2, extra;
    set_phase(6'b001000);
    ncyc(2);
    raw_coin = 1'b1;
    ncyc(6);
    coin_rtn = 1'b1;
    wait_sol(ok);
    raw_coin = 1'b0;
    count_high(n1);
    count_low(g);
    count_high(n2);
    coin_rtn = 1'b0;
    count_any_high(20, extra);
    checks += 5;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: got no pulse expected pulse"); end
    if (n1 !== 8) begin errors++; $display("FAIL b2b_pulse1: got %0d expected 8", n1); end
    if (g !== 2) begin errors++; $display("FAIL b2b_gap: got %0d expected 2", g); end
    if (n2 !== 8) begin errors++; $display("FAIL b2b_pulse2: got %0d expected 8", n2); end
    if (extra !== 0) begin errors++; $display("FAIL b2b_extra: got %0d expected 0", extra); end
  endtask

  task automatic test_reset_mid_pulse;
    bit ok;
    int hi;
    raw_coin = 1'b1;
    ncyc(6);
    coin_rtn = 1'b1;
    wait_sol(ok);
    ncyc(3);
    raw_coin = 1'b0;
    coin_rtn = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (!ok) begin errors++; $display("FAIL midrst_timeout: got no pulse expected pulse"); end
    if (rtn_solenoid !== 1'b0) begin errors++; $display("FAIL midrst_drop: got %0b expected 0", rtn_solenoid); end
    ncyc(2);
    rst_n = 1'b1;
    count_any_high(30, hi);
    checks++;
    if (hi !== 0) begin errors++; $display("FAIL midrst_no_second: got %0d high cycles expected 0", hi); end
  endtask

  task automatic test_coin_count;
    int exp_total;
    checks++;
    if (coin_total !== 16'd0) begin errors++; $display("FAIL count_after_reset: got %0d expected 0", coin_total); end
    for (int i = 0; i < 3; i++) begin
      set_phase(6'b100000);
      ncyc(1);
      press(0);
      checks++;
      if (coin !== 1'b1) begin errors++; $display("FAIL count_accept%0d: got %0b expected 1", i, coin); end
      if (i < 2) begin
        set_phase(6'b010000);
        ncyc(1);
      end else begin
        raw_cancel = 1'b1;
        ncyc(8);
        checks += 2;
        if (cancel !== 1'b1) begin errors++; $display("FAIL cancel_level: got %0b expected 1", cancel); end
        if (coin !== 1'b0) begin errors++; $display("FAIL cancel_clear: got %0b expected 0", coin); end
        raw_cancel = 1'b0;
        ncyc(10);
      end
    end
    set_phase(6'b001000);
    ncyc(1);
    press(0);
    ncyc(5);
    checks++;
    if (coin !== 1'b0) begin errors++; $display("FAIL count_reject_coin: got %0b expected 0", coin); end
`ifdef WM_COIN_COUNT_EN
    exp_total = 3;
`else
    exp_total = 0;
`endif
    checks++;
    if (coin_total !== 16'(exp_total)) begin errors++; $display("FAIL coin_total: got %0d expected %0d", coin_total, exp_total); end
  endtask

  initial begin
    rst_n = 1'b0;
    raw_lid = 1'b0; raw_coin = 1'b0; raw_cancel = 1'b0; raw_mode_btn = 1'b0;
    idle_op = 1'b0; ready_op = 1'b0; soak_op = 1'b0; wash_op = 1'b0;
    rinse_op = 1'b0; spin_op = 1'b0; coin_rtn = 1'b0;
    test_reset;
    test_lid;
    test_coin_accept;
    test_coin_reject;
    test_mode;
    test_phase;
    test_back_to_back;
    test_reset_mid_pulse;
    test_coin_count;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
